dsp_mac_slice: RTL and testbench
================================

// Module: dsp_mac_slice
// PURPOSE
//  Parametrised pre-add/multiply/post-add MAC slice; next-generation DSP48A1-class block.
//  Adds generic operand widths, optional input/multiplier pipeline stages, per-op OPMODE
//  carried down the pipe, valid tracking with bubble-safe accumulation, optional saturation.
//  Sits in datapaths (FIR taps, MAC engines) as the arithmetic primitive between operand regs and result logic.
// PARAMETERS
//  A_WIDTH  18  signed multiplier operand A width
//  B_WIDTH  18  signed B / D width; pre-adder result is B_WIDTH+1
//  C_WIDTH  48  signed C operand width, sign-extended to P_WIDTH
//  P_WIDTH  48  result width; must be >= A_WIDTH+B_WIDTH+1 (elaboration error otherwise)
//  IREG     1   0/1: input register stage on A,B,D,C,OPMODE,CARRYIN,IN_VALID
//  MREG     1   0/1: register after multiplier
// PORTS
//  CLK       in   1        clock, all logic on rising edge
//  RSTN      in   1        synchronous active-low reset
//  CE        in   1        clock enable for every pipeline register (1 = advance)
//  IN_VALID  in   1        operands/OPMODE valid this cycle
//  OPMODE    in   6        [0] preadd sub, [1] use preadder, [3:2] Z sel, [4] X zero, [5] post sub
//  A         in   A_WIDTH  multiplier operand
//  B         in   B_WIDTH  pre-adder operand / direct multiplier operand
//  D         in   B_WIDTH  pre-adder operand
//  C         in   C_WIDTH  post-adder operand
//  CARRYIN   in   1        post-adder carry in
//  P         out  P_WIDTH  result register
//  CARRYOUT  out  1        carry out of post-adder (bit P_WIDTH of unsigned sum)
//  OUT_VALID out  1        P updated with a valid result this cycle
//  SAT_FLAG  out  1        sticky saturation indicator (0 when feature compiled out)
// BEHAVIOUR
//  - Stages: S1 inputs (if IREG) -> S2 pre-add reg -> S3 mult reg (if MREG) -> S4 post-add/P reg.
//    Latency L = IREG+MREG+2 valid-cycles (default 4); one op/cycle throughput.
//  - S2: PRE = OPMODE[1] ? (OPMODE[0] ? D-B : D+B) : B, sign-extended to B_WIDTH+1.
//  - S3: M = A * PRE, signed, full A_WIDTH+B_WIDTH+1 bits, sign-extended to P_WIDTH.
//  - S4: X = OPMODE[4] ? 0 : M; Z by [3:2]: 00 zero, 01 P (current P reg), 10 C, 11 C+P.
//    P = OPMODE[5] ? Z-(X+CARRYIN) : Z+X+CARRYIN, mod 2^P_WIDTH; CARRYOUT from same add.
//  - OPMODE and CARRYIN travel with their operands; each op uses its own mode at every stage.
//  - Valid bit shifts with data; a stage register loads only when CE=1 and its incoming valid=1.
//    Bubbles (IN_VALID=0) never modify P/CARRYOUT, so accumulation survives gaps.
//  - CE=0: all stages, valid bits and P hold; OUT_VALID forced 0 during stall.
//  - OUT_VALID=1 for exactly one cycle per result, the cycle after P loads.
//  - Reset (RSTN=0 at edge) has priority over CE: all data, valid, P, CARRYOUT, SAT_FLAG -> 0.
//    Reset mid-operation discards all in-flight ops; OUT_VALID=0 until new ops traverse L stages.
//  - Back-to-back accumulate (Z=01) ops each see the P from the preceding valid op.
// CONFIGURATION
//  Macro DSP_MAC_SAT_EN:
//  - defined: S4 computes in P_WIDTH+1 bits; signed overflow clamps P to 2^(P_WIDTH-1)-1 or
//    -2^(P_WIDTH-1); SAT_FLAG set on clamp, sticky until reset. CARRYOUT unaffected by clamp.
//  - undefined: P wraps modulo 2^P_WIDTH; SAT_FLAG tied 0; no extra logic.
// TESTING
//  1 defaults, A=3,B=5,D=2,OPMODE=6'b000010, one valid -> P=21, OUT_VALID pulse 4 cycles later.
//  2 OPMODE=6'b000110, A=1,B=1,D=0, 10 valids with bubbles interleaved, P from 0 -> P=10,
//    10 OUT_VALID pulses, P unchanged across bubbles.
//  3 CE=0 for 3 cycles mid-stream of 4 ops -> same P sequence as unstalled, delayed 3 cycles.
//  4 RSTN=0 one cycle with 3 ops in flight -> P=0, no OUT_VALID for those ops, next op latency 4.
//  5 C=all ones(-1), Z=10, M=1 (A=1,B=1,no preadd), CARRYIN=0 -> P=0, CARRYOUT=1.
//  6 C=2^47-1, M=1: with DSP_MAC_SAT_EN P=0x7FFF_FFFF_FFFF, SAT_FLAG=1;
//    without P=0x8000_0000_0000, SAT_FLAG=0.

Source files
------------

// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: pre-add / multiply / post-add MAC slice with valid tracking.
// Define DSP_MAC_SAT_EN to clamp P on signed overflow and drive a sticky SAT_FLAG.
module dsp_mac_slice #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int C_WIDTH = 48,
  parameter int P_WIDTH = 48,
  parameter int IREG    = 1,
  parameter int MREG    = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic [5:0]         OPMODE,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [B_WIDTH-1:0] D,
  input  logic [C_WIDTH-1:0] C,
  input  logic               CARRYIN,
  output logic [P_WIDTH-1:0] P,
  output logic               CARRYOUT,
  output logic               OUT_VALID,
  output logic               SAT_FLAG
);

  localparam int PRE_W = B_WIDTH + 1;
  localparam int M_W   = A_WIDTH + PRE_W;

  if (P_WIDTH < M_W) begin : g_bad_p
    $error("dsp_mac_slice: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
  end
  if (C_WIDTH > P_WIDTH) begin : g_bad_c
    $error("dsp_mac_slice: C_WIDTH must be <= P_WIDTH");
  end

  logic               v1, ci1;
  logic [5:0]         op1;
  logic [A_WIDTH-1:0] a1;
  logic [B_WIDTH-1:0] b1, d1;
  logic [C_WIDTH-1:0] c1;

  if (IREG != 0) begin : g_ireg
    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        v1  <= 1'b0;
        ci1 <= 1'b0;
        op1 <= '0;
        a1  <= '0;
        b1  <= '0;
        d1  <= '0;
        c1  <= '0;
      end else if (CE) begin
        v1 <= IN_VALID;
        if (IN_VALID) begin
          ci1 <= CARRYIN;
          op1 <= OPMODE;
          a1  <= A;
          b1  <= B;
          d1  <= D;
          c1  <= C;
        end
      end
    end
  end else begin : g_no_ireg
    assign v1  = IN_VALID;
    assign ci1 = CARRYIN;
    assign op1 = OPMODE;
    assign a1  = A;
    assign b1  = B;
    assign d1  = D;
    assign c1  = C;
  end

  logic [PRE_W-1:0] pre_d;

  always_comb begin
    pre_d = {b1[B_WIDTH-1], b1};
    if (op1[1]) begin
      if (op1[0])
        pre_d = {d1[B_WIDTH-1], d1} - {b1[B_WIDTH-1], b1};
      else
        pre_d = {d1[B_WIDTH-1], d1} + {b1[B_WIDTH-1], b1};
    end
  end

  // Only OPMODE[5:2] is needed past the pre-adder.
  logic               v2, ci2;
  logic [3:0]         op2;
  logic [A_WIDTH-1:0] a2;
  logic [PRE_W-1:0]   pre2;
  logic [C_WIDTH-1:0] c2;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      v2   <= 1'b0;
      ci2  <= 1'b0;
      op2  <= '0;
      a2   <= '0;
      pre2 <= '0;
      c2   <= '0;
    end else if (CE) begin
      v2 <= v1;
      if (v1) begin
        ci2  <= ci1;
        op2  <= op1[5:2];
        a2   <= a1;
        pre2 <= pre_d;
        c2   <= c1;
      end
    end
  end

  logic [M_W-1:0] m_d;

  assign m_d = $signed({{PRE_W{a2[A_WIDTH-1]}}, a2})
             * $signed({{A_WIDTH{pre2[PRE_W-1]}}, pre2});

  logic               v3, ci3;
  logic [3:0]         op3;
  logic [M_W-1:0]     m3;
  logic [C_WIDTH-1:0] c3;

  if (MREG != 0) begin : g_mreg
    always_ff @(posedge CLK) begin
      if (!RSTN) begin
        v3  <= 1'b0;
        ci3 <= 1'b0;
        op3 <= '0;
        m3  <= '0;
        c3  <= '0;
      end else if (CE) begin
        v3 <= v2;
        if (v2) begin
          ci3 <= ci2;
          op3 <= op2;
          m3  <= m_d;
          c3  <= c2;
        end
      end
    end
  end else begin : g_no_mreg
    assign v3  = v2;
    assign ci3 = ci2;
    assign op3 = op2;
    assign m3  = m_d;
    assign c3  = c2;
  end

  logic [P_WIDTH-1:0] m_ext, c_ext, x_s, z_s, p_d;
  logic [P_WIDTH:0]   usum;

  assign m_ext = P_WIDTH'($signed(m3));
  assign c_ext = P_WIDTH'($signed(c3));

  // op3: [0]/[1] Z select, [2] X zero, [3] post subtract.
  always_comb begin
    x_s = op3[2] ? '0 : m_ext;
    unique case (op3[1:0])
      2'b00:   z_s = '0;
      2'b01:   z_s = P;
      2'b10:   z_s = c_ext;
      default: z_s = c_ext + P;
    endcase
    if (op3[3])
      usum = {1'b0, z_s} - {1'b0, x_s} - {{P_WIDTH{1'b0}}, ci3};
    else
      usum = {1'b0, z_s} + {1'b0, x_s} + {{P_WIDTH{1'b0}}, ci3};
  end

`ifdef DSP_MAC_SAT_EN
  logic [P_WIDTH:0] ssum;
  logic             ovf;
  logic             sat_q;

  always_comb begin
    if (op3[3])
      ssum = {z_s[P_WIDTH-1], z_s} - {x_s[P_WIDTH-1], x_s}
           - {{P_WIDTH{1'b0}}, ci3};
    else
      ssum = {z_s[P_WIDTH-1], z_s} + {x_s[P_WIDTH-1], x_s}
           + {{P_WIDTH{1'b0}}, ci3};
    ovf = ssum[P_WIDTH] ^ ssum[P_WIDTH-1];
    p_d = ssum[P_WIDTH-1:0];
    if (ovf)
      p_d = {ssum[P_WIDTH], {(P_WIDTH-1){~ssum[P_WIDTH]}}};
  end

  always_ff @(posedge CLK) begin
    if (!RSTN)
      sat_q <= 1'b0;
    else if (CE && v3 && ovf)
      sat_q <= 1'b1;
  end

  assign SAT_FLAG = sat_q;
`else
  assign p_d      = usum[P_WIDTH-1:0];
  assign SAT_FLAG = 1'b0;
`endif

  // Bubbles leave P/CARRYOUT untouched so accumulation spans gaps.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      P         <= '0;
      CARRYOUT  <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (CE) begin
      OUT_VALID <= v3;
      if (v3) begin
        P        <= p_d;
        CARRYOUT <= usum[P_WIDTH];
      end
    end else begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_mac_slice.sv
// tb_dsp_mac_slice: directed-vector bench for dsp_mac_slice (default parameters).
// Expected values for the overflow case follow DSP_MAC_SAT_EN.
module tb_dsp_mac_slice;

  logic        CLK = 1'b0;
  logic        RSTN, CE, IN_VALID, CARRYIN;
  logic [5:0]  OPMODE;
  logic [17:0] A, B, D;
  logic [47:0] C;
  logic [47:0] P;
  logic        CARRYOUT, OUT_VALID, SAT_FLAG;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dsp_mac_slice dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .CE        (CE),
    .IN_VALID  (IN_VALID),
    .OPMODE    (OPMODE),
    .A         (A),
    .B         (B),
    .D         (D),
    .C         (C),
    .CARRYIN   (CARRYIN),
    .P         (P),
    .CARRYOUT  (CARRYOUT),
    .OUT_VALID (OUT_VALID),
    .SAT_FLAG  (SAT_FLAG)
  );

  task automatic put(input logic v, input logic [17:0] a, b, d,
                     input logic [47:0] c, input logic [5:0] op,
                     input logic ci);
    IN_VALID = v;
    A        = a;
    B        = b;
    D        = d;
    C        = c;
    OPMODE   = op;
    CARRYIN  = ci;
    @(negedge CLK);
  endtask

  task automatic idle();
    put(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    CE   = 1'b1;
    idle();
    idle();
    RSTN = 1'b1;
  endtask

  task automatic run_op(input logic [17:0] a, b, d, input logic [47:0] c,
                        input logic [5:0] op, input logic ci,
                        output int lat);
    put(1'b1, a, b, d, c, op, ci);
    lat = 1;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      idle();
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (P !== 48'd0) begin
      n_err++;
      $display("FAIL reset_p: got %h expected 0", P);
    end
    n_vec++;
    if ({CARRYOUT, OUT_VALID, SAT_FLAG} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000",
               {CARRYOUT, OUT_VALID, SAT_FLAG});
    end
  endtask

  task automatic test_basic();
    do_reset();
    put(1'b1, 18'd3, 18'd5, 18'd2, '0, 6'b000010, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      n_vec++;
      if (OUT_VALID !== (k == 3)) begin
        n_err++;
        $display("FAIL basic_valid_%0d: got %b expected %b",
                 k, OUT_VALID, (k == 3));
      end
    end
    n_vec++;
    if (P !== 48'd21) begin
      n_err++;
      $display("FAIL basic_p: got %0d expected 21", P);
    end
  endtask

  task automatic test_accumulate();
    int np;
    do_reset();
    np = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 20 && cyc % 2 == 0)
        put(1'b1, 18'd1, 18'd1, 18'd0, '0, 6'b000110, 1'b0);
      else
        idle();
      if (OUT_VALID === 1'b1) np++;
      n_vec++;
      if (P !== 48'(np)) begin
        n_err++;
        $display("FAIL accum_p_c%0d: got %0d expected %0d", cyc, P, np);
      end
    end
    n_vec++;
    if (np != 10) begin
      n_err++;
      $display("FAIL accum_pulses: got %0d expected 10", np);
    end
  endtask

  task automatic test_stall();
    int idx;
    logic exp_ov;
    logic [47:0] exp_p [4];
    exp_p = '{48'd1, 48'd3, 48'd6, 48'd10};
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      CE = !(cyc >= 2 && cyc <= 4);
      if (idx < 4)
        put(1'b1, 18'(idx + 1), 18'd1, 18'd0, '0, 6'b000100, 1'b0);
      else
        idle();
      if (CE && idx < 4) idx++;
      exp_ov = (cyc >= 6 && cyc <= 9);
      n_vec++;
      if (OUT_VALID !== exp_ov) begin
        n_err++;
        $display("FAIL stall_valid_c%0d: got %b expected %b",
                 cyc, OUT_VALID, exp_ov);
      end
      if (exp_ov) begin
        n_vec++;
        if (P !== exp_p[cyc-6]) begin
          n_err++;
          $display("FAIL stall_p_c%0d: got %0d expected %0d",
                   cyc, P, exp_p[cyc-6]);
        end
      end
    end
    CE = 1'b1;
  endtask

  task automatic test_reset_inflight();
    int lat;
    for (int k = 0; k < 3; k++)
      put(1'b1, 18'd2, 18'd3, 18'd0, '0, 6'b000000, 1'b0);
    RSTN = 1'b0;
    idle();
    RSTN = 1'b1;
    n_vec++;
    if (P !== 48'd0 || OUT_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flight_p: got %0d/%b expected 0/0", P, OUT_VALID);
    end
    for (int k = 0; k < 6; k++) begin
      idle();
      n_vec++;
      if (OUT_VALID !== 1'b0 || P !== 48'd0) begin
        n_err++;
        $display("FAIL rst_flight_quiet_%0d: got %b/%0d expected 0/0",
                 k, OUT_VALID, P);
      end
    end
    run_op(18'd2, 18'd3, 18'd0, '0, 6'b000000, 1'b0, lat);
    n_vec++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL rst_flight_latency: got %0d expected 4", lat);
    end
    n_vec++;
    if (P !== 48'd6) begin
      n_err++;
      $display("FAIL rst_flight_p_new: got %0d expected 6", P);
    end
  endtask

  task automatic test_carry();
    int lat;
    run_op(18'd1, 18'd1, 18'd0, {48{1'b1}}, 6'b001000, 1'b0, lat);
    n_vec++;
    if (P !== 48'd0 || CARRYOUT !== 1'b1) begin
      n_err++;
      $display("FAIL carry_wrap: got %h/%b expected 0/1", P, CARRYOUT);
    end
    run_op(18'd2, 18'd3, 18'd0, 48'd10, 6'b101000, 1'b1, lat);
    n_vec++;
    if (P !== 48'd3 || CARRYOUT !== 1'b0) begin
      n_err++;
      $display("FAIL post_sub: got %h/%b expected 3/0", P, CARRYOUT);
    end
    run_op(18'h3FFFE, 18'd3, 18'd10, '0, 6'b000011, 1'b0, lat);
    n_vec++;
    if (P !== 48'hFFFF_FFFF_FFF2 || CARRYOUT !== 1'b0) begin
      n_err++;
      $display("FAIL pre_sub_neg: got %h/%b expected fffffffffff2/0",
               P, CARRYOUT);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [47:0] exp_p;
    logic exp_sat;
`ifdef DSP_MAC_SAT_EN
    exp_p   = 48'h7FFF_FFFF_FFFF;
    exp_sat = 1'b1;
`else
    exp_p   = 48'h8000_0000_0000;
    exp_sat = 1'b0;
`endif
    do_reset();
    run_op(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 6'b001000, 1'b0, lat);
    n_vec++;
    if (P !== exp_p) begin
      n_err++;
      $display("FAIL ovf_p: got %h expected %h", P, exp_p);
    end
    n_vec++;
    if (SAT_FLAG !== exp_sat) begin
      n_err++;
      $display("FAIL ovf_flag: got %b expected %b", SAT_FLAG, exp_sat);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    CE   = 1'b1;
    IN_VALID = 1'b0;
    A = '0;
    B = '0;
    D = '0;
    C = '0;
    OPMODE  = '0;
    CARRYIN = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_accumulate();
    test_stall();
    test_reset_inflight();
    test_carry();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
